// File: rtl/led_driver_wb_data_master_if.sv
// led_driver_wb_data_master_if: single-read Wishbone bus between the frame-data master and the mem slave.
interface led_driver_wb_data_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wbm_address;
  logic [DATA_WIDTH-1:0] wbm_writedata;
  logic [DATA_WIDTH-1:0] wbm_readdata;
  logic                  wbm_strobe;
  logic                  wbm_cycle;
  logic                  wbm_write;
  logic                  wbm_ack;
  modport master (
    output wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    input  wbm_readdata, wbm_ack
  );
  modport slave (
    input  wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
    output wbm_readdata, wbm_ack
  );
endinterface

// File: rtl/led_driver_wb_data_master.sv
// led_driver_wb_data_master: fetches buffer words one read per request and hands each to the LED core with a valid pulse.
module led_driver_wb_data_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BUF_WORDS_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_driver_wb_data_master_if.master bus,
  input  logic [DATA_WIDTH-1:0] buf_id_i,
  input  logic                  wb_request_first_word_i,
  input  logic                  wb_request_next_word_i,
  output logic                  wb_recieved_new_word_o,
  output logic [DATA_WIDTH-1:0] wb_received_word_o
);
  typedef enum logic {IDLE, READ} state_t;
  state_t                    state_q;
  logic [DATA_WIDTH-1:0]     cur_buf_q, cur_buf_d, word_q;
  logic [BUF_WORDS_LOG2-1:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      cyc_q, pulse_q, req;
  // first-word wins when both requests arrive together; idx+1 wraps within the buffer
  always_comb begin
    req        = wb_request_first_word_i || wb_request_next_word_i;
    cur_buf_d  = wb_request_first_word_i ? buf_id_i : cur_buf_q;
    word_idx_d = wb_request_first_word_i ? '0 : word_idx_q + 1'b1;
    addr_d     = ADDR_WIDTH'(cur_buf_d << BUF_WORDS_LOG2) + ADDR_WIDTH'(word_idx_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_buf_q  <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      cyc_q      <= 1'b0;
      pulse_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (state_q == IDLE) begin
        if (req) begin
          state_q    <= READ;
          cyc_q      <= 1'b1;
          cur_buf_q  <= cur_buf_d;
          word_idx_q <= word_idx_d;
          addr_q     <= addr_d;
        end
      end else if (bus.wbm_ack) begin
        state_q <= IDLE;
        cyc_q   <= 1'b0;
        word_q  <= bus.wbm_readdata;
        pulse_q <= 1'b1;
      end
    end
  end
  assign bus.wbm_address        = addr_q;
  assign bus.wbm_writedata      = '0;
  assign bus.wbm_cycle          = cyc_q;
  assign bus.wbm_strobe         = cyc_q;
  assign bus.wbm_write          = 1'b0;
  assign wb_recieved_new_word_o = pulse_q;
  assign wb_received_word_o     = word_q;
endmodule

// File: tb/tb_led_driver_wb_data_master.sv
// tb_led_driver_wb_data_master: directed reads against a mem slave model whose word a holds 32'hC0DE0000 | a.
module tb_led_driver_wb_data_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] buf_id = '0;
  logic        first = 1'b0, next = 1'b0;
  logic        pulse;
  logic [31:0] word;
  int          checks = 0, errors = 0, pulse_cnt = 0, waits = 0, wcnt = 0, base;
  led_driver_wb_data_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
  led_driver_wb_data_master dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .buf_id_i(buf_id), .wb_request_first_word_i(first), .wb_request_next_word_i(next),
    .wb_recieved_new_word_o(pulse), .wb_received_word_o(word)
  );
  always #5 clk = ~clk;
  assign bus.wbm_ack      = bus.wbm_cycle && bus.wbm_strobe && (wcnt == waits);
  assign bus.wbm_readdata = 32'hC0DE0000 | {16'h0, bus.wbm_address};
  always @(posedge clk) begin
    wcnt <= (bus.wbm_cycle && !bus.wbm_ack) ? wcnt + 1 : 0;
    if (pulse) pulse_cnt <= pulse_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_pulse(input int budget);
    int n = 0;
    while (!pulse && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_seen", {31'b0, pulse}, 32'd1);
  endtask
  task automatic do_read(input logic f, input logic n, input logic [31:0] b, input logic [15:0] exp_addr);
    int p0;
    @(negedge clk);
    p0 = pulse_cnt;
    first = f; next = n; buf_id = b;
    @(negedge clk);
    first = 1'b0; next = 1'b0;
    chk("cyc_up", {31'b0, bus.wbm_cycle}, 32'd1);
    chk("addr", {16'b0, bus.wbm_address}, {16'b0, exp_addr});
    wait_pulse(50);
    chk("word", word, 32'hC0DE0000 | {16'b0, exp_addr});
    chk("cyc_down", {31'b0, bus.wbm_cycle}, 32'd0);
    @(negedge clk);
    chk("one_pulse", pulse_cnt - p0, 1);
  endtask
  initial begin
    repeat (100) @(negedge clk);
    chk("rst_cyc", {31'b0, bus.wbm_cycle}, 32'd0);
    chk("rst_stb", {31'b0, bus.wbm_strobe}, 32'd0);
    chk("rst_we", {31'b0, bus.wbm_write}, 32'd0);
    chk("rst_wdata", bus.wbm_writedata, 32'd0);
    chk("rst_pulse", {31'b0, pulse}, 32'd0);
    chk("rst_word", word, 32'd0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_cyc", {31'b0, bus.wbm_cycle}, 32'd0);
    end
    for (int r = 0; r < 5; r++) begin
      do_read(1'b1, 1'b0, 32'd0, 16'h0000);
      for (int i = 1; i <= 10; i++) do_read(1'b0, 1'b1, 32'd0, 16'(i));
      repeat (3) @(negedge clk);
    end
    do_read(1'b1, 1'b0, 32'd3, 16'h0300);
    for (int i = 1; i <= 256; i++) do_read(1'b0, 1'b1, 32'd9, 16'h0300 + 16'(i % 256));
    // stalled read: requests raised mid-stall must neither redirect nor queue
    waits = 5;
    @(negedge clk);
    base = pulse_cnt;
    first = 1'b1; buf_id = 32'd5;
    @(negedge clk);
    first = 1'b0;
    chk("stall_addr0", {16'b0, bus.wbm_address}, 32'h0500);
    first = 1'b1; next = 1'b1; buf_id = 32'd7;
    repeat (3) @(negedge clk);
    first = 1'b0; next = 1'b0;
    chk("stall_cyc", {31'b0, bus.wbm_cycle}, 32'd1);
    chk("stall_addr1", {16'b0, bus.wbm_address}, 32'h0500);
    chk("stall_nopulse", {31'b0, pulse}, 32'd0);
    wait_pulse(50);
    chk("stall_word", word, 32'hC0DE0500);
    repeat (3) begin
      @(negedge clk);
      chk("no_queue", {31'b0, bus.wbm_cycle}, 32'd0);
    end
    chk("stall_pulses", pulse_cnt - base, 1);
    waits = 0;
    do_read(1'b1, 1'b1, 32'd2, 16'h0200);
    // reset mid-read: bus drops at once, no valid pulse for the aborted read
    waits = 20;
    @(negedge clk);
    base = pulse_cnt;
    first = 1'b1; buf_id = 32'd1;
    @(negedge clk);
    first = 1'b0;
    chk("abort_cyc_up", {31'b0, bus.wbm_cycle}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cyc", {31'b0, bus.wbm_cycle}, 32'd0);
    chk("abort_stb", {31'b0, bus.wbm_strobe}, 32'd0);
    chk("abort_addr", {16'b0, bus.wbm_address}, 32'd0);
    chk("abort_word", word, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_nopulse", pulse_cnt - base, 0);
    waits = 0;
    do_read(1'b0, 1'b1, 32'd4, 16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
